// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the writeback arbiter: register index width and the queued
// result entry.
package wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_arbiter_if.sv
// Producer, forwarding and register-file-write signals of the writeback arbiter.
// The slave modport is the arbiter's view of these signals.
interface writeback_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
);
  logic                            mem_valid, mem_ready;
  logic [wb_pkg::REG_ADDR_W-1:0]   mem_rd;
  logic [DATA_W-1:0]               mem_data;
  logic                            alu_valid, alu_ready;
  logic [wb_pkg::REG_ADDR_W-1:0]   alu_rd;
  logic [DATA_W-1:0]               alu_data;
  logic [wb_pkg::REG_ADDR_W-1:0]   fwd_rd;
  logic                            fwd_hit;
  logic [DATA_W-1:0]               fwd_data;
  logic                            reg_write;
  logic [wb_pkg::REG_ADDR_W-1:0]   write_register;
  logic [DATA_W-1:0]               write_data;
  logic [$clog2(DEPTH):0]          occupancy;

  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, fwd_rd,
    output mem_ready, alu_ready, fwd_hit, fwd_data,
           reg_write, write_register, write_data, occupancy
  );
  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, fwd_rd,
    input  mem_ready, alu_ready, fwd_hit, fwd_data,
           reg_write, write_register, write_data, occupancy
  );
endinterface

// File: rtl/writeback_arbiter_fifo.sv
// Circular result queue: two ordered push ports (port 0 is older), one pop,
// per-entry valid bits and a parallel rd compare for forwarding.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push0_i,
  input  wb_entry_t             push0_data_i,
  input  logic                  push1_i,
  input  wb_entry_t             push1_data_i,
  input  logic                  pop_i,
  input  logic [REG_ADDR_W-1:0] cmp_rd_i,
  output wb_entry_t             head_o,
  output logic [PW-1:0]         head_ptr_o,
  output wb_entry_t [DEPTH-1:0] ent_o,
  output logic [DEPTH-1:0]      match_o,
  output logic [PW:0]           count_o
);
  wb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d, tail1;
  logic [PW:0]           cnt_q, cnt_d;

  always_comb begin
    ent_d  = ent_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail1  = tail_q;
    if (pop_i) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (push0_i) begin
      ent_d[tail_q] = push0_data_i;
      vld_d[tail_q] = 1'b1;
      tail1         = tail_q + PW'(1);
    end
    // Port 1 lands in the slot after port 0 so same-cycle pushes stay ordered.
    if (push1_i) begin
      ent_d[tail1] = push1_data_i;
      vld_d[tail1] = 1'b1;
    end
    tail_d = tail1 + PW'(push1_i);
    cnt_d  = cnt_q + (PW+1)'(push0_i) + (PW+1)'(push1_i) - (PW+1)'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q  <= '0;
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent_q  <= ent_d;
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    match_o = '0;
    for (int i = 0; i < DEPTH; i++)
      match_o[i] = vld_q[i] && (ent_q[i].rd == cmp_rd_i);
  end

  assign head_o     = ent_q[head_q];
  assign head_ptr_o = head_q;
  assign ent_o      = ent_q;
  assign count_o    = cnt_q;
endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results into the single register-file write port through
// an in-order queue, with a combinational forwarding lookup over pending values.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  writeback_arbiter_if.slave wb
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]           occ, free;
  logic                  mem_push, alu_push, pop;
  wb_entry_t             mem_ent, alu_ent, head;
  wb_entry_t [DEPTH-1:0] ent;
  logic [DEPTH-1:0]      match;
  logic [PW-1:0]         head_ptr, idx;
  logic                  rw_q, rw_d;
  logic [REG_ADDR_W-1:0] wr_q, wr_d;
  logic [DATA_W-1:0]     wd_q, wd_d;
  logic                  hit;
  logic [DATA_W-1:0]     hit_data;

  // Credit is taken from the pre-pop occupancy only; a full queue cannot accept.
  assign free         = (PW+1)'(DEPTH) - occ;
  assign wb.mem_ready = rst_n && (free >= (PW+1)'(1));
  assign wb.alu_ready = rst_n && (wb.mem_valid ? (free >= (PW+1)'(2))
                                               : (free >= (PW+1)'(1)));

  assign mem_push = wb.mem_valid && wb.mem_ready && (wb.mem_rd != '0);
  assign alu_push = wb.alu_valid && wb.alu_ready && (wb.alu_rd != '0);
  assign mem_ent  = '{rd: wb.mem_rd, data: wb.mem_data};
  assign alu_ent  = '{rd: wb.alu_rd, data: wb.alu_data};
  assign pop      = (occ != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push0_i      (mem_push),
    .push0_data_i (mem_ent),
    .push1_i      (alu_push),
    .push1_data_i (alu_ent),
    .pop_i        (pop),
    .cmp_rd_i     (wb.fwd_rd),
    .head_o       (head),
    .head_ptr_o   (head_ptr),
    .ent_o        (ent),
    .match_o      (match),
    .count_o      (occ)
  );

  always_comb begin
    rw_d = pop;
    wr_d = wr_q;
    wd_d = wd_q;
    if (pop) begin
      wr_d = head.rd;
      wd_d = head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q <= 1'b0;
      wr_q <= '0;
      wd_q <= '0;
    end else begin
      rw_q <= rw_d;
      wr_q <= wr_d;
      wd_q <= wd_d;
    end
  end

  // Walk oldest to youngest so a younger match overrides; output stage is oldest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    if (wb.fwd_rd != '0) begin
      if (rw_q && (wr_q == wb.fwd_rd)) begin
        hit      = 1'b1;
        hit_data = wd_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_ptr + PW'(k);
        if (match[idx]) begin
          hit      = 1'b1;
          hit_data = ent[idx].data;
        end
      end
    end
  end

  assign wb.fwd_hit        = hit;
  assign wb.fwd_data       = hit_data;
  assign wb.reg_write      = rw_q;
  assign wb.write_register = wr_q;
  assign wb.write_data     = wd_q;
  assign wb.occupancy      = occ;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a queue scoreboard of accepted results.
`timescale 1ns/100ps
module tb_writeback_arbiter;
  import wb_pkg::*;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_arbiter_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bif();
  writeback_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .wb(bif.slave));

  int        errs = 0;
  int        checks = 0;
  wb_entry_t sbq[$];
  logic        exp_rw = 1'b0;
  logic [4:0]  exp_wr = '0;
  logic [63:0] exp_wd = '0;
  logic        macc, aacc;
  int          mi, ai;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fwd(logic [4:0] rd);
    logic        h = 1'b0;
    logic [63:0] d = '0;
    if (rd != 5'd0) begin
      if (exp_rw && exp_wr == rd) begin h = 1'b1; d = exp_wd; end
      foreach (sbq[i]) if (sbq[i].rd == rd) begin h = 1'b1; d = sbq[i].data; end
    end
    bif.fwd_rd = rd;
    #1;
    chk("fwd_hit", 64'(bif.fwd_hit), 64'(h));
    chk("fwd_data", bif.fwd_data, d);
  endtask

  // One clock: check readies/occupancy/forwarding at negedge, outputs after posedge.
  task automatic cyc(logic [4:0] frd);
    int        free;
    logic      er_m, er_a;
    wb_entry_t e;
    @(negedge clk);
    free = DEPTH - sbq.size();
    er_m = (free >= 1);
    er_a = bif.mem_valid ? (free >= 2) : (free >= 1);
    chk("mem_ready", 64'(bif.mem_ready), 64'(er_m));
    chk("alu_ready", 64'(bif.alu_ready), 64'(er_a));
    chk("occupancy", 64'(bif.occupancy), 64'(sbq.size()));
    chk_fwd(frd);
    macc = bif.mem_valid && er_m;
    aacc = bif.alu_valid && er_a;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      exp_rw = 1'b1; exp_wr = e.rd; exp_wd = e.data;
    end else exp_rw = 1'b0;
    if (macc && bif.mem_rd != 5'd0) begin
      e.rd = bif.mem_rd; e.data = bif.mem_data; sbq.push_back(e);
    end
    if (aacc && bif.alu_rd != 5'd0) begin
      e.rd = bif.alu_rd; e.data = bif.alu_data; sbq.push_back(e);
    end
    chk("reg_write", 64'(bif.reg_write), 64'(exp_rw));
    chk("write_register", 64'(bif.write_register), 64'(exp_wr));
    chk("write_data", bif.write_data, exp_wd);
  endtask

  task automatic drive(logic mv, logic [4:0] mr, logic [63:0] md,
                       logic av, logic [4:0] ar, logic [63:0] ad);
    bif.mem_valid = mv; bif.mem_rd = mr; bif.mem_data = md;
    bif.alu_valid = av; bif.alu_rd = ar; bif.alu_data = ad;
  endtask

  initial begin
    drive(1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2);
    bif.fwd_rd = 5'd0;
    #12;
    chk("rst_reg_write", 64'(bif.reg_write), 64'd0);
    chk("rst_write_register", 64'(bif.write_register), 64'd0);
    chk("rst_write_data", bif.write_data, 64'd0);
    chk("rst_occupancy", 64'(bif.occupancy), 64'd0);
    chk("rst_mem_ready", 64'(bif.mem_ready), 64'd0);
    chk("rst_alu_ready", 64'(bif.alu_ready), 64'd0);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single ALU push
    drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 64'h1234);
    cyc(5'd5);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    cyc(5'd5);
    cyc(5'd5);
    cyc(5'd5);

    // same-cycle mem/alu to the same register
    drive(1'b1, 5'd3, 64'hA, 1'b1, 5'd3, 64'hB);
    cyc(5'd3);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    for (int k = 0; k < 4; k++) cyc(5'd3);

    // rd == 0 accepted but discarded
    drive(1'b1, 5'd0, 64'h55, 1'b1, 5'd0, 64'h66);
    cyc(5'd0);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    cyc(5'd0);
    cyc(5'd0);

    // both producers every cycle; a stalled ALU result is held until accepted
    mi = 0; ai = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 5'(8 + mi % 8), 64'h100 + 64'(mi),
            1'b1, 5'(16 + ai % 8), 64'h200 + 64'(ai));
      cyc(5'(16 + ai % 8));
      if (macc) mi++;
      if (aacc) ai++;
    end
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    for (int k = 0; k < 6; k++) cyc(5'(8 + k));

    // reset with three entries queued and a write in flight
    drive(1'b1, 5'd7, 64'h77, 1'b1, 5'd9, 64'h99);
    cyc(5'd7);
    drive(1'b1, 5'd10, 64'hAA, 1'b1, 5'd11, 64'hBB);
    cyc(5'd9);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    chk("pre_rst_occupancy", 64'(bif.occupancy), 64'd3);
    chk("pre_rst_reg_write", 64'(bif.reg_write), 64'd1);
    #2 rst_n = 1'b0;
    sbq.delete();
    exp_rw = 1'b0; exp_wr = '0; exp_wd = '0;
    #1;
    chk("arst_reg_write", 64'(bif.reg_write), 64'd0);
    chk("arst_write_register", 64'(bif.write_register), 64'd0);
    chk("arst_write_data", bif.write_data, 64'd0);
    chk("arst_occupancy", 64'(bif.occupancy), 64'd0);
    chk("arst_mem_ready", 64'(bif.mem_ready), 64'd0);
    chk("arst_alu_ready", 64'(bif.alu_ready), 64'd0);
    chk_fwd(5'd10);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cyc(5'd11);
    for (int r = 1; r < 32; r++) chk_fwd(5'(r));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Write-side companion to the register file: collects completed results from the ALU and load/store unit and drives the register file's single write port, one write per cycle. Results are buffered in a small in-order queue. A forwarding lookup port exposes any queued or in-flight value, so decode-stage readers never see a stale register. Sits between the execute/memory stages and the register file write port.

## Interface
- DATA_W, 64, result and register-write data width
- DEPTH, 4, queue entries; power of two, ≥2

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- mem_valid  in  1  load-unit result present
- mem_ready  out  1  load result accepted this cycle
- mem_rd  in  5  destination register of load result
- mem_data  in  DATA_W  load result
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  5  destination register of ALU result
- alu_data  in  DATA_W  ALU result
- fwd_rd  in  5  register index being read by decode
- fwd_hit  out  1  fwd_rd has a pending, not-yet-written value
- fwd_data  out  DATA_W  youngest pending value for fwd_rd
- reg_write  out  1  register file write enable
- write_register  out  5  register file write index
- write_data  out  DATA_W  register file write data
- occupancy  out  $clog2(DEPTH)+1  queued entries, excluding output stage

## Operation
- A transfer on a source occurs when valid && ready are both high at a rising edge.
- free = DEPTH − occupancy, sampled before this cycle's pop. There is no same-cycle pop credit.
- mem_ready = (free ≥ 1).
- alu_ready = (free ≥ 2) when mem_valid is high, else (free ≥ 1).
- Both sources accepted in one cycle: the mem entry is enqueued first (older), then the alu entry.
- rd == 0 transfers are accepted normally but not stored; occupancy is unaffected.
- Drain: every cycle with occupancy > 0, the head is popped into the output registers and reg_write is set to 1. Otherwise reg_write = 0; write_register and write_data hold their last values.
- Push and pop in the same cycle are legal. Occupancy changes by (pushes − pop).
- Forwarding is combinational on fwd_rd:
  - Search queue entries from youngest to oldest, then the output stage when reg_write = 1.
  - First match gives fwd_hit = 1 and fwd_data = its data.
  - No match, or fwd_rd == 0, gives fwd_hit = 0 and fwd_data = 0.
- Multiple entries for the same rd are legal and are written in arrival order.
- Reset values: reg_write = 0, write_register = 0, write_data = 0, occupancy = 0, head and tail pointers 0, all entry-valid bits 0. While rst_n is low, mem_ready = 0 and alu_ready = 0.
- Reset mid-operation discards all queued and output-stage contents immediately.

## Timing
- Result accepted at edge N (empty queue) → reg_write = 1 with that data during cycle N+1 → register file updated at edge N+2.
- Sustained throughput: one write per cycle. With two producers each pushing every cycle, the queue fills and alu_ready drops first.
- The forwarding path is purely combinational. It covers every cycle from acceptance (edge N) until the register file write edge (N+2), inclusive of the output stage.
- Pointers wrap modulo DEPTH. Full (occupancy == DEPTH) forces both readies low. Empty produces no pop.

## Structure
- Package wb_pkg holds:
  - REG_ADDR_W = 5
  - typedef wb_entry_t {logic [REG_ADDR_W-1:0] rd; logic [DATA_W-1:0] data;}
- Sub-module wb_fifo: circular buffer with dual push ports (ordered), single pop, per-entry valid bits and a parallel rd-compare output for the forwarding search.
- Top level contains the ready logic, the output register stage and the youngest-match priority select.

## Test plan
- Single ALU push rd=5, data=0x1234 into an empty queue → reg_write=1, write_register=5, write_data=0x1234 exactly one cycle later; occupancy returns to 0.
- Same-cycle mem rd=3/0xA and alu rd=3/0xB → writes appear in order 0xA then 0xB on consecutive cycles. fwd_rd=3 returns 0xB until after the second write cycle, then fwd_hit=0.
- Both sources push every cycle for 8 cycles with DEPTH=4 → alu_ready low once free<2, mem_ready low at full; no entry lost or reordered; occupancy never exceeds 4.
- Push with rd=0 → ready=1, no reg_write, occupancy unchanged; fwd_rd=0 gives fwd_hit=0.
- Assert rst_n low with 3 entries queued and reg_write=1 → all outputs and occupancy go to 0 asynchronously. After release, no stale writes appear and fwd_hit=0 for all registers.
